// File: rtl/sha1_msg_sequencer_if.sv
// Bus bundle between the SHA-1 message sequencer and its byte source, core and digest consumer.
// The slave view is the sequencer; the master view drives the opposite side of every signal.
interface sha1_msg_sequencer_if;
    logic [7:0]   s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_block;
    logic         core_ready;
    logic [159:0] core_digest;
    logic [159:0] m_digest;
    logic         m_digest_valid;
    logic         m_digest_ready;
    logic         busy;
    logic         len_overflow;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, core_ready, core_digest, m_digest_ready,
        output s_axis_tready, core_init, core_next, core_block, m_digest, m_digest_valid, busy,
               len_overflow
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, core_ready, core_digest, m_digest_ready,
        input  s_axis_tready, core_init, core_next, core_block, m_digest, m_digest_valid, busy,
               len_overflow
    );
endinterface

// File: rtl/sha1_msg_sequencer.sv
// Packs a byte stream into 512-bit SHA-1 blocks, applies message padding in hardware and
// sequences sha1_core with init/next pulses, returning the final digest over valid/ready.
module sha1_msg_sequencer #(
    parameter int unsigned LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sha1_msg_sequencer_if.slave  bus
);
    localparam int unsigned BLK_W = 512;
    localparam int unsigned DIG_W = 160;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned POS_W = 9;

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_PAD0, S_PADZ, S_LEN, S_DISPATCH, S_HOLD, S_WAIT, S_OUT
    } state_e;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               final_q, final_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic               tready_q, tready_d;
    logic               init_q, init_d;
    logic               next_q, next_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic               dval_q, dval_d;
    logic [POS_W-1:0]   pos_c;
    logic               accept_c;

    // Top bit of byte slot k; byte 0 lands in [511:504].
    assign pos_c    = POS_W'(POS_W'(511) - {idx_q, 3'b000});
    assign accept_c = tready_q & bus.s_axis_tvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            final_q  <= 1'b0;
            blk_q    <= '0;
            tready_q <= 1'b0;
            init_q   <= 1'b0;
            next_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dig_q    <= '0;
            dval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            final_q  <= final_d;
            blk_q    <= blk_d;
            tready_q <= tready_d;
            init_q   <= init_d;
            next_q   <= next_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            dig_q    <= dig_d;
            dval_q   <= dval_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        final_d = final_q;
        blk_d   = blk_q;
        init_d  = 1'b0;
        next_d  = 1'b0;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        dval_d  = dval_q;

        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept_c) begin
                    blk_d[pos_c -: 8] = bus.s_axis_tdata;
                    idx_d = idx_q + IDX_W'(1);
                    if (state_q == S_IDLE) begin
                        cnt_d   = LEN_W'(1);
                        final_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if (&cnt_q) ovf_d = 1'b1;
                    end
                    // Slot 63 filled: idx wraps to 0 and the block goes out before any padding.
                    if (bus.s_axis_tlast && (idx_q == IDX_W'(63))) begin
                        state_d = S_DISPATCH;
                        ret_d   = S_PAD0;
                    end else if (bus.s_axis_tlast) begin
                        state_d = S_PAD0;
                    end else if (idx_q == IDX_W'(63)) begin
                        state_d = S_DISPATCH;
                        ret_d   = S_FILL;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_PAD0: begin
                blk_d[pos_c -: 8] = 8'h80;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q < IDX_W'(56)) begin
                    state_d = S_PADZ;
                end else begin
                    // No room for the length field: zero the tail and spill into one more block.
                    for (int j = 0; j < 64; j++) begin
                        if (IDX_W'(j) > idx_q) blk_d[POS_W'(511 - 8 * j) -: 8] = 8'h00;
                    end
                    idx_d   = '0;
                    state_d = S_DISPATCH;
                    ret_d   = S_PADZ;
                end
            end
            S_PADZ: begin
                if (idx_q == IDX_W'(56)) begin
                    state_d = S_LEN;
                end else begin
                    blk_d[pos_c -: 8] = 8'h00;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(55)) state_d = S_LEN;
                end
            end
            S_LEN: begin
                blk_d[63:0] = 64'({cnt_q, 3'b000});
                idx_d       = '0;
                final_d     = 1'b1;
                state_d     = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (bus.core_ready) begin
                    init_d  = first_q;
                    next_d  = ~first_q;
                    first_d = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.core_ready) begin
                    idx_d = '0;
                    if (final_q) begin
                        dig_d   = bus.core_digest;
                        dval_d  = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        state_d = ret_q;
                    end
                end
            end
            S_OUT: begin
                if (bus.m_digest_ready) begin
                    dval_d  = 1'b0;
                    first_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status flags are registered decodes of the next state.
    assign tready_d = (state_d == S_IDLE) || (state_d == S_FILL);
    assign busy_d   = (state_d != S_IDLE);

    assign bus.s_axis_tready  = tready_q;
    assign bus.core_init      = init_q;
    assign bus.core_next      = next_q;
    assign bus.core_block     = blk_q;
    assign bus.m_digest       = dig_q;
    assign bus.m_digest_valid = dval_q;
    assign bus.busy           = busy_q;
    assign bus.len_overflow   = ovf_q;

endmodule
